// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer
//
// Receive-side width converter for a valid/ready stream. Drains a narrow
// stream (typically a FIFO read port), packs RATIO consecutive beats into one
// wide word (first beat in lane 0) and presents the word on a registered
// valid/ready output. While the word is held, input ready follows output
// ready combinationally, so a full-rate stream passes with no bubbles.
//
// Configuration macro: STREAM_PACKER_PARTIAL_EN
//   defined   : data_in_last_i flushes a partially filled word; keep marks
//               the lanes that hold received data.
//   undefined : data_in_last_i is ignored; every word has RATIO beats.
//
// Parameters:
//   WIDTH            width of one input beat
//   RATIO            input beats per output word (>= 2)
//
// Ports:
//   clk_i            clock, rising edge
//   arst_ni          asynchronous reset, active low
//   data_in_i        input beat
//   data_in_valid_i  input beat valid
//   data_in_ready_o  block accepts a beat this cycle
//   data_in_last_i   beat ends the word (partial-flush builds only)
//   data_out_o       packed word, lane k = [k*WIDTH +: WIDTH]
//   data_out_keep_o  bit k set when lane k holds received data
//   data_out_valid_o packed word valid
//   data_out_ready_i consumer accepts the word
// -----------------------------------------------------------------------------
module stream_packer #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                   clk_i,
   input  logic                   arst_ni,
   input  logic [WIDTH-1:0]       data_in_i,
   input  logic                   data_in_valid_i,
   output logic                   data_in_ready_o,
   input  logic                   data_in_last_i,
   output logic [WIDTH*RATIO-1:0] data_out_o,
   output logic [RATIO-1:0]       data_out_keep_o,
   output logic                   data_out_valid_o,
   input  logic                   data_out_ready_i
);

   localparam int CW = $clog2(RATIO);

   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   logic [0:0]             r_state;
   logic [0:0]             w_state_next;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_next;
   logic [WIDTH*RATIO-1:0] r_data;
   logic [WIDTH*RATIO-1:0] w_data_next;
   logic [RATIO-1:0]       r_keep;
   logic [RATIO-1:0]       w_keep_next;

   logic w_in_hs;
   logic w_out_hs;
   logic w_clear;
   logic w_word_end;
   logic w_last;

`ifdef STREAM_PACKER_PARTIAL_EN
   assign w_last = data_in_last_i;
`else
   logic w_unused_last;
   assign w_unused_last = data_in_last_i;
   assign w_last        = 1'b0;
`endif

   assign data_out_valid_o = (r_state == HOLD);
   // Ready is combinational from the output side while holding: a beat can be
   // taken on the same edge the held word leaves.
   assign data_in_ready_o  = (r_state == FILL) || data_out_ready_i;

   assign w_in_hs  = data_in_valid_i && data_in_ready_o;
   assign w_out_hs = data_out_valid_o && data_out_ready_i;

   // cnt is always 0 in HOLD, so a beat accepted there lands in lane 0 and
   // starts a clean word exactly like the first beat in FILL.
   assign w_clear    = w_in_hs && (r_cnt == '0);
   assign w_word_end = (r_cnt == CW'(RATIO - 1)) || w_last;

   // Per-lane write / clear. Lanes not yet written in a new word are cleared
   // so unused lanes read as zero.
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      logic w_lane_wr;
      assign w_lane_wr = w_in_hs && (r_cnt == CW'(gi));

      always_comb begin
         w_data_next[gi*WIDTH +: WIDTH] = r_data[gi*WIDTH +: WIDTH];
         w_keep_next[gi]                = r_keep[gi];
         if (w_lane_wr) begin
            w_data_next[gi*WIDTH +: WIDTH] = data_in_i;
            w_keep_next[gi]                = 1'b1;
         end else if (w_clear) begin
            w_data_next[gi*WIDTH +: WIDTH] = '0;
            w_keep_next[gi]                = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      if (r_state == HOLD) begin
         if (w_out_hs) begin
            w_state_next = FILL;
            if (w_in_hs) begin
               // Beat taken into lane 0 of the next word; a single-beat
               // partial word goes straight back to HOLD.
               if (w_last) begin
                  w_state_next = HOLD;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next   = CW'(1);
               end
            end
         end
      end else if (w_in_hs) begin
         if (w_word_end) begin
            w_state_next = HOLD;
            w_cnt_next   = '0;
         end else begin
            w_cnt_next   = r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_state <= FILL;
         r_cnt   <= '0;
         r_data  <= '0;
         r_keep  <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_data  <= w_data_next;
         r_keep  <= w_keep_next;
      end
   end

   assign data_out_o      = r_data;
   assign data_out_keep_o = r_keep;

endmodule

// File: tb/tb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_packer
//
// Directed testbench for stream_packer (WIDTH=8, RATIO=4). Inputs are driven
// on the falling edge and outputs sampled on the falling edge, half a cycle
// away from the active rising edge. Honours STREAM_PACKER_PARTIAL_EN for the
// partial-flush scenario.
// -----------------------------------------------------------------------------
module tb_stream_packer;

   logic        clk_i;
   logic        arst_ni;
   logic [7:0]  data_in_i;
   logic        data_in_valid_i;
   logic        data_in_ready_o;
   logic        data_in_last_i;
   logic [31:0] data_out_o;
   logic [3:0]  data_out_keep_o;
   logic        data_out_valid_o;
   logic        data_out_ready_i;

   int total;
   int bad;

   stream_packer #(
      .WIDTH(8),
      .RATIO(4)
   ) dut (
      .clk_i            (clk_i),
      .arst_ni          (arst_ni),
      .data_in_i        (data_in_i),
      .data_in_valid_i  (data_in_valid_i),
      .data_in_ready_o  (data_in_ready_o),
      .data_in_last_i   (data_in_last_i),
      .data_out_o       (data_out_o),
      .data_out_keep_o  (data_out_keep_o),
      .data_out_valid_o (data_out_valid_o),
      .data_out_ready_i (data_out_ready_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Drives n beats of w (lane 0 first) on consecutive falling edges; returns
   // right after presenting the last beat, so the caller's next falling edge
   // comes after the edge that accepts it.
   task automatic send_beats(input logic [31:0] w, input int n, input logic last_on_final);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_i);
         data_in_i       = w[8*i +: 8];
         data_in_valid_i = 1'b1;
         data_in_last_i  = last_on_final && (i == n - 1);
      end
   endtask

   task automatic test_reset;
      arst_ni          = 1'b0;
      data_in_i        = 8'h00;
      data_in_valid_i  = 1'b0;
      data_in_last_i   = 1'b0;
      data_out_ready_i = 1'b1;
      @(negedge clk_i);
      total++;
      if (data_out_valid_o !== 1'b0) begin
         bad++; $display("FAIL reset_valid got=%0b want=0", data_out_valid_o);
      end
      total++;
      if (data_out_o !== 32'h0) begin
         bad++; $display("FAIL reset_data got=%08h want=00000000", data_out_o);
      end
      total++;
      if (data_out_keep_o !== 4'h0) begin
         bad++; $display("FAIL reset_keep got=%0h want=0", data_out_keep_o);
      end
      total++;
      if (data_in_ready_o !== 1'b1) begin
         bad++; $display("FAIL reset_ready got=%0b want=1", data_in_ready_o);
      end
      arst_ni = 1'b1;
      $display("reset: valid=%0b data=%08h keep=%0h", data_out_valid_o, data_out_o, data_out_keep_o);
   endtask

   task automatic test_full_word;
      data_out_ready_i = 1'b1;
      send_beats(32'h44332211, 4, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h44332211 || data_out_keep_o !== 4'hF) begin
         bad++;
         $display("FAIL full_word got valid=%0b data=%08h keep=%0h want valid=1 data=44332211 keep=f",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
      total++;
      if (data_out_valid_o !== 1'b0) begin
         bad++; $display("FAIL full_word_drop got valid=%0b want=0", data_out_valid_o);
      end
      $display("full_word: data=%08h", data_out_o);
   endtask

   task automatic test_back_to_back;
      logic [63:0] beats;
      beats = 64'h0807060504030201;
      data_out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         if (i == 4) begin
            total++;
            if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h04030201) begin
               bad++;
               $display("FAIL b2b_word0 got valid=%0b data=%08h want valid=1 data=04030201",
                        data_out_valid_o, data_out_o);
            end
         end
         if (i == 5) begin
            // 5th beat and first output handshake shared one edge
            total++;
            if (data_out_valid_o !== 1'b0 || data_out_o !== 32'h00000005 || data_out_keep_o !== 4'h1) begin
               bad++;
               $display("FAIL b2b_overlap got valid=%0b data=%08h keep=%0h want valid=0 data=00000005 keep=1",
                        data_out_valid_o, data_out_o, data_out_keep_o);
            end
         end
         data_in_i       = beats[8*i +: 8];
         data_in_valid_i = 1'b1;
         data_in_last_i  = 1'b0;
         total++;
         if (data_in_ready_o !== 1'b1) begin
            bad++; $display("FAIL b2b_ready beat=%0d got=%0b want=1", i, data_in_ready_o);
         end
      end
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h08070605 || data_out_keep_o !== 4'hF) begin
         bad++;
         $display("FAIL b2b_word1 got valid=%0b data=%08h keep=%0h want valid=1 data=08070605 keep=f",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
      total++;
      if (data_out_valid_o !== 1'b0) begin
         bad++; $display("FAIL b2b_drop got valid=%0b want=0", data_out_valid_o);
      end
      $display("back_to_back: words 04030201 08070605");
   endtask

   task automatic test_back_pressure;
      data_out_ready_i = 1'b0;
      send_beats(32'hDDCCBBAA, 4, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'hDDCCBBAA) begin
         bad++;
         $display("FAIL bp_word got valid=%0b data=%08h want valid=1 data=ddccbbaa",
                  data_out_valid_o, data_out_o);
      end
      for (int c = 0; c < 10; c++) begin
         // Offer beats that must be ignored while stalled
         data_in_i       = 8'hE0 + 8'(c);
         data_in_valid_i = c[0];
         @(negedge clk_i);
         total++;
         if (data_in_ready_o !== 1'b0 || data_out_valid_o !== 1'b1 ||
             data_out_o !== 32'hDDCCBBAA || data_out_keep_o !== 4'hF) begin
            bad++;
            $display("FAIL bp_stall cyc=%0d got ready=%0b valid=%0b data=%08h keep=%0h want ready=0 valid=1 data=ddccbbaa keep=f",
                     c, data_in_ready_o, data_out_valid_o, data_out_o, data_out_keep_o);
         end
      end
      data_out_ready_i = 1'b1;
      data_in_i        = 8'h55;
      data_in_valid_i  = 1'b1;
      #1;
      total++;
      if (data_in_ready_o !== 1'b1) begin
         bad++; $display("FAIL bp_release_ready got=%0b want=1", data_in_ready_o);
      end
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b0 || data_out_o !== 32'h00000055 || data_out_keep_o !== 4'h1) begin
         bad++;
         $display("FAIL bp_release got valid=%0b data=%08h keep=%0h want valid=0 data=00000055 keep=1",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      send_beats(32'h00887766, 3, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h88776655) begin
         bad++;
         $display("FAIL bp_followup got valid=%0b data=%08h want valid=1 data=88776655",
                  data_out_valid_o, data_out_o);
      end
      @(negedge clk_i);
      $display("back_pressure: held ddccbbaa, then 88776655");
   endtask

   task automatic test_partial;
      data_out_ready_i = 1'b1;
      send_beats(32'h0000BBAA, 2, 1'b1);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      data_in_last_i  = 1'b0;
`ifdef STREAM_PACKER_PARTIAL_EN
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h0000BBAA || data_out_keep_o !== 4'h3) begin
         bad++;
         $display("FAIL partial_flush got valid=%0b data=%08h keep=%0h want valid=1 data=0000bbaa keep=3",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
      total++;
      if (data_out_valid_o !== 1'b0) begin
         bad++; $display("FAIL partial_drop got valid=%0b want=0", data_out_valid_o);
      end
`else
      @(negedge clk_i);
      total++;
      if (data_out_valid_o !== 1'b0) begin
         bad++; $display("FAIL partial_ignored got valid=%0b want=0", data_out_valid_o);
      end
      send_beats(32'hDDCC0000 >> 16, 2, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'hDDCCBBAA || data_out_keep_o !== 4'hF) begin
         bad++;
         $display("FAIL partial_full got valid=%0b data=%08h keep=%0h want valid=1 data=ddccbbaa keep=f",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
`endif
      $display("partial: data=%08h keep=%0h", data_out_o, data_out_keep_o);
   endtask

   task automatic test_reset_mid_word;
      data_out_ready_i = 1'b1;
      send_beats(32'h00002211, 2, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      arst_ni         = 1'b0;
      #1;
      total++;
      if (data_out_valid_o !== 1'b0 || data_out_o !== 32'h0 || data_out_keep_o !== 4'h0) begin
         bad++;
         $display("FAIL midreset got valid=%0b data=%08h keep=%0h want valid=0 data=00000000 keep=0",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
      arst_ni = 1'b1;
      send_beats(32'h04030201, 4, 1'b0);
      @(negedge clk_i);
      data_in_valid_i = 1'b0;
      total++;
      if (data_out_valid_o !== 1'b1 || data_out_o !== 32'h04030201 || data_out_keep_o !== 4'hF) begin
         bad++;
         $display("FAIL midreset_word got valid=%0b data=%08h keep=%0h want valid=1 data=04030201 keep=f",
                  data_out_valid_o, data_out_o, data_out_keep_o);
      end
      @(negedge clk_i);
      $display("reset_mid_word: data=04030201 after reset");
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_full_word();
      test_back_to_back();
      test_back_pressure();
      test_partial();
      test_reset_mid_word();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
